// File: rtl/viterbi_out_deser.sv
// Purpose : packs the decoded serial bit stream into WORD_W-bit words and queues them in a small FWFT FIFO
// Latency : the last bit of a word accepted on edge N reaches data_o/valid_o after edge N if the FIFO was empty
// Backpr. : input is never stalled; a word completed while the FIFO is full and not popping is dropped (sticky overflow_o)
// Build option: define VITERBI_DESER_MSB_FIRST_EN to fill each word from bit WORD_W-1 downward (default LSB-first).
module viterbi_out_deser #(
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid_serial_i,
  input  logic                          data_serial_i,
  input  logic                          flush_i,
  output logic [WORD_W-1:0]             data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o
);

  localparam int CW = $clog2(WORD_W);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  // assembly state
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic [CW-1:0]     bit_idx;
  logic [WORD_W-1:0] asm_q;
  logic [WORD_W-1:0] asm_bit;
  logic              word_done;
  logic              flush_push;
  logic              push;
  logic [WORD_W-1:0] push_word;

  // FIFO state
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_ptr_nxt;
  logic [LW-1:0]     level_after_pop;
  logic [LW-1:0]     level_nxt;
  logic [WORD_W-1:0] data_nxt;
  logic              pop;
  logic              push_ok;
  logic              drop;

  // Insert this cycle's bit and decide whether a word (full or flushed partial) leaves the assembler.
  always_comb begin
`ifdef VITERBI_DESER_MSB_FIRST_EN
    bit_idx = CW'(WORD_W - 1) - cnt;
`else
    bit_idx = cnt;
`endif
    asm_bit = asm_q;
    if (valid_serial_i) begin
      asm_bit[bit_idx] = data_serial_i;
    end
    word_done  = valid_serial_i && (cnt == CW'(WORD_W - 1));
    // A flush only emits when at least one bit is pending after this cycle's bit, and never
    // on the edge a word completes (that word already carries the bits).
    flush_push = flush_i && !word_done && (valid_serial_i || (cnt != '0));
    push       = word_done || flush_push;
    // Unfilled positions are zero because asm_q is cleared after every push.
    push_word  = asm_bit;
    if (push) begin
      cnt_nxt = '0;
    end else if (valid_serial_i) begin
      cnt_nxt = cnt + CW'(1);
    end else begin
      cnt_nxt = cnt;
    end
  end

  // Bit counter and assembly register; cleared on every push so the next word starts empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      asm_q <= '0;
    end else begin
      cnt   <= cnt_nxt;
      asm_q <= push ? '0 : asm_bit;
    end
  end

  // FIFO next-state: pop/push arbitration, exact level, and the next head word for data_o.
  always_comb begin
    pop             = valid_o && ready_i;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    push_ok         = push && ((fifo_level_o != LW'(FIFO_DEPTH)) || pop);
    drop            = push && !push_ok;
    rd_ptr_nxt      = rd_ptr + PW'(pop);
    level_after_pop = fifo_level_o - LW'(pop);
    level_nxt       = level_after_pop + LW'(push_ok);
    // data_o holds when the FIFO goes empty; the incoming word bypasses to data_o when it
    // becomes the head, otherwise the surviving entry at the new read pointer is shown.
    data_nxt        = data_o;
    if (level_after_pop != '0) begin
      data_nxt = mem[rd_ptr_nxt];
    end else if (push_ok) begin
      data_nxt = push_word;
    end
  end

  // Storage array write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // Pointers, level, registered outputs and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level_o <= '0;
      valid_o      <= 1'b0;
      data_o       <= '0;
      overflow_o   <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr + PW'(push_ok);
      rd_ptr       <= rd_ptr_nxt;
      fifo_level_o <= level_nxt;
      valid_o      <= (level_nxt != '0);
      data_o       <= data_nxt;
      overflow_o   <= overflow_o | drop;
    end
  end

endmodule

// File: tb/tb_viterbi_out_deser.sv
// Purpose : exercises viterbi_out_deser with directed scenarios and randomized traffic against a queue model
// Latency : model outputs are compared 1 time unit after every rising edge
// Backpr. : ready_i is driven both directed and at randomly varying acceptance rates
module tb_viterbi_out_deser;

  localparam int W = 8;
  localparam int D = 4;

`ifdef VITERBI_DESER_MSB_FIRST_EN
  localparam logic [W-1:0] EXP_WORD  = 8'hB2;
  localparam logic [W-1:0] EXP_FLUSH = 8'hE0;
`else
  localparam logic [W-1:0] EXP_WORD  = 8'h4D;
  localparam logic [W-1:0] EXP_FLUSH = 8'h07;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_serial_i;
  logic         data_serial_i;
  logic         flush_i;
  logic [W-1:0] data_o;
  logic         valid_o;
  logic         ready_i;
  logic [2:0]   fifo_level_o;
  logic         overflow_o;

  always #5 clk = ~clk;

  viterbi_out_deser #(.WORD_W(W), .FIFO_DEPTH(D)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_serial_i (valid_serial_i),
    .data_serial_i  (data_serial_i),
    .flush_i        (flush_i),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .fifo_level_o   (fifo_level_o),
    .overflow_o     (overflow_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: pending bits in arrival order, queued words, sticky drop flag, shown word.
  bit           bits_q[$];
  logic [W-1:0] fifo_q[$];
  bit           m_ovf  = 1'b0;
  logic [W-1:0] m_data = '0;

  function automatic logic [W-1:0] pack_bits();
    logic [W-1:0] w = '0;
    for (int i = 0; i < bits_q.size(); i++) begin
`ifdef VITERBI_DESER_MSB_FIRST_EN
      w[W-1-i] = bits_q[i];
`else
      w[i] = bits_q[i];
`endif
    end
    return w;
  endfunction

  task automatic model_edge(input bit v, input bit d, input bit fl, input bit rdy, input bit rn);
    bit           pop;
    bit           have;
    logic [W-1:0] w;
    if (!rn) begin
      bits_q.delete();
      fifo_q.delete();
      m_ovf  = 1'b0;
      m_data = '0;
      return;
    end
    pop  = (fifo_q.size() > 0) && rdy;
    have = 1'b0;
    w    = '0;
    if (v) bits_q.push_back(d);
    if ((bits_q.size() == W) || (fl && (bits_q.size() > 0))) begin
      w    = pack_bits();
      have = 1'b1;
      bits_q.delete();
    end
    if (pop) void'(fifo_q.pop_front());
    if (have) begin
      if (fifo_q.size() < D) fifo_q.push_back(w);
      else m_ovf = 1'b1;
    end
    if (fifo_q.size() > 0) m_data = fifo_q[0];
  endtask

  // One clock: drive inputs, advance the model with the edge, compare all outputs after it.
  task automatic step(input bit v, input bit d, input bit fl, input bit rdy, input bit rn);
    valid_serial_i = v;
    data_serial_i  = d;
    flush_i        = fl;
    ready_i        = rdy;
    rst_n          = rn;
    @(posedge clk);
    model_edge(v, d, fl, rdy, rn);
    #1;
    check("valid", 32'(valid_o), 32'(fifo_q.size() > 0));
    check("level", 32'(fifo_level_o), 32'(fifo_q.size()));
    check("overflow", 32'(overflow_o), 32'(m_ovf));
    check("data", 32'(data_o), 32'(m_data));
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit rdy_body, input bit rdy_last);
    logic [W-1:0] wv;
    wv = w;
    for (int i = 0; i < W; i++) begin
`ifdef VITERBI_DESER_MSB_FIRST_EN
      step(1'b1, wv[W-1-i], 1'b0, (i == W-1) ? rdy_last : rdy_body, 1'b1);
`else
      step(1'b1, wv[i], 1'b0, (i == W-1) ? rdy_last : rdy_body, 1'b1);
`endif
    end
  endtask

  initial begin
    bit seq[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int pulses;
    logic [W-1:0] got;
    int rdy_pct;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_level", 32'(fifo_level_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);

    // Word assembly, back-to-back bits
    for (int i = 0; i < 8; i++) step(1'b1, seq[i], 1'b0, 1'b1, 1'b1);
    check("asm_valid", 32'(valid_o), 32'd1);
    check("asm_data", 32'(data_o), 32'(EXP_WORD));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("asm_pulse_end", 32'(valid_o), 32'd0);

    // Gapped input: one pulse with the same word
    pulses = 0;
    got    = '0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, seq[i], 1'b0, 1'b1, 1'b1);
      if (valid_o) begin pulses++; got = data_o; end
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      if (valid_o) begin pulses++; got = data_o; end
    end
    check("gap_pulses", 32'(pulses), 32'd1);
    check("gap_data", 32'(got), 32'(EXP_WORD));

    // Flush of a 3-bit partial word, then a flush with nothing pending
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("flush_data", 32'(data_o), 32'(EXP_FLUSH));
    check("flush_level", 32'(fifo_level_o), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("flush_drained", 32'(fifo_level_o), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("flush_empty_none", 32'(valid_o), 32'd0);

    // Back-pressure and overflow
    for (int k = 1; k <= 4; k++) send_word(W'(k), 1'b0, 1'b0);
    check("bp_full", 32'(fifo_level_o), 32'd4);
    check("bp_no_ovf_yet", 32'(overflow_o), 32'd0);
    send_word(8'h05, 1'b0, 1'b0);
    check("bp_ovf", 32'(overflow_o), 32'd1);
    check("bp_level_kept", 32'(fifo_level_o), 32'd4);
    for (int k = 1; k <= 4; k++) begin
      check("bp_drain_order", 32'(data_o), 32'(k));
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    check("bp_empty_valid", 32'(valid_o), 32'd0);
    check("bp_empty_level", 32'(fifo_level_o), 32'd0);
    check("bp_ovf_sticky", 32'(overflow_o), 32'd1);

    // Full FIFO with a pop on the exact edge a new word completes
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) send_word(W'(k), 1'b0, 1'b0);
    send_word(8'h05, 1'b0, 1'b1);
    check("fp_level", 32'(fifo_level_o), 32'd4);
    check("fp_no_ovf", 32'(overflow_o), 32'd0);
    for (int k = 2; k <= 5; k++) begin
      check("fp_order", 32'(data_o), 32'(k));
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    end

    // Reset mid-operation
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mr_level", 32'(fifo_level_o), 32'd0);
    check("mr_valid", 32'(valid_o), 32'd0);
    check("mr_ovf", 32'(overflow_o), 32'd0);
    send_word(8'hA5, 1'b0, 1'b0);
    check("mr_fresh_level", 32'(fifo_level_o), 32'd1);
    check("mr_fresh_data", 32'(data_o), 32'hA5);

    // Randomized traffic with varying consumer acceptance rate
    rdy_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if ((c % 250) == 0) rdy_pct = $urandom_range(0, 100);
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 99) < rdy_pct,
           $urandom_range(0, 599) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
